// File: rtl/sprite_pos_regs_if.sv
// Wishbone classic-cycle bundle between the sprite master and the sprite position register file.
// Carries the decoder chip select, the request struct and the response struct.
interface sprite_pos_regs_if;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_write_request32_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] dat;
  } wb_read_response32_t;

  logic                cs;
  wb_write_request32_t wb_req;
  wb_read_response32_t wb_resp;

  modport master (
    output cs,
    output wb_req,
    input  wb_resp
  );

  modport slave (
    input  cs,
    input  wb_req,
    output wb_resp
  );

endinterface

// File: rtl/sprite_pos_regs.sv
// Double-banked sprite position/size/enable registers: CPU writes staging, vsync copies to active.
// Optional macro SPRITE_POS_REGS_READBACK_EN builds the Wishbone read mux over the staging bank.
module sprite_pos_regs #(
  parameter int unsigned NSPR     = 32,
  parameter logic [7:0]  DEF_SIZE = 8'd16
) (
  input  logic                clk,
  input  logic                rst_n,
  sprite_pos_regs_if.slave    wb,
  input  logic                vsync_i,
  input  logic [4:0]          spr_idx_i,
  output logic [11:0]         spr_hpos_o,
  output logic [11:0]         spr_vpos_o,
  output logic [7:0]          spr_w_o,
  output logic [7:0]          spr_h_o,
  output logic                spr_en_o,
  output logic                frame_upd_o
);

  localparam int unsigned IW = (NSPR > 1) ? $clog2(NSPR) : 1;

  logic [11:0] stg_hpos_q [NSPR];
  logic [11:0] stg_vpos_q [NSPR];
  logic [7:0]  stg_w_q    [NSPR];
  logic [7:0]  stg_h_q    [NSPR];
  logic        stg_en_q   [NSPR];

  logic [11:0] act_hpos_q [NSPR];
  logic [11:0] act_vpos_q [NSPR];
  logic [7:0]  act_w_q    [NSPR];
  logic [7:0]  act_h_q    [NSPR];
  logic        act_en_q   [NSPR];

  logic          ack_q;
  logic          vsync_q;
  logic          copy;
  logic          req;
  logic          req_valid;
  logic          wr_en;
  logic [4:0]    adr_spr;
  logic [1:0]    adr_reg;
  logic          adr_ok;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] lk_idx;
  logic [31:0]   wdat;
  logic [3:0]    sel;

  assign adr_spr   = wb.wb_req.adr[8:4];
  assign adr_reg   = wb.wb_req.adr[3:2];
  assign adr_ok    = (wb.wb_req.adr[31:9] == '0) && (32'(adr_spr) < NSPR);
  assign wr_idx    = adr_spr[IW-1:0];
  assign lk_idx    = spr_idx_i[IW-1:0];
  assign wdat      = wb.wb_req.dat;
  assign sel       = wb.wb_req.sel;

  assign req       = wb.cs & wb.wb_req.cyc & wb.wb_req.stb;
  // A request is taken only while ack is low, so a held strobe commits exactly once.
  assign req_valid = req & ~ack_q;
  assign wr_en     = req_valid & wb.wb_req.we & adr_ok;
  assign copy      = vsync_i & ~vsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q       <= 1'b0;
      vsync_q     <= 1'b1;
      frame_upd_o <= 1'b0;
    end else begin
      ack_q       <= req;
      vsync_q     <= vsync_i;
      frame_upd_o <= copy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSPR; i++) begin
        stg_hpos_q[i] <= '0;
        stg_vpos_q[i] <= '0;
        stg_w_q[i]    <= DEF_SIZE;
        stg_h_q[i]    <= DEF_SIZE;
        stg_en_q[i]   <= 1'b0;
      end
    end else if (wr_en) begin
      case (adr_reg)
        2'd0: begin
          if (sel[0]) stg_hpos_q[wr_idx][7:0]  <= wdat[7:0];
          if (sel[1]) stg_hpos_q[wr_idx][11:8] <= wdat[11:8];
          if (sel[2]) stg_vpos_q[wr_idx][7:0]  <= wdat[23:16];
          if (sel[3]) stg_vpos_q[wr_idx][11:8] <= wdat[27:24];
        end
        2'd1: begin
          if (sel[0]) stg_w_q[wr_idx] <= wdat[7:0];
          if (sel[1]) stg_h_q[wr_idx] <= wdat[15:8];
        end
        2'd2: begin
          if (sel[0]) stg_en_q[wr_idx] <= wdat[0];
        end
        default: ;
      endcase
    end
  end

  // Nonblocking copy picks up pre-write staging when a write commits on the copy edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSPR; i++) begin
        act_hpos_q[i] <= '0;
        act_vpos_q[i] <= '0;
        act_w_q[i]    <= DEF_SIZE;
        act_h_q[i]    <= DEF_SIZE;
        act_en_q[i]   <= 1'b0;
      end
    end else if (copy) begin
      for (int i = 0; i < NSPR; i++) begin
        act_hpos_q[i] <= stg_hpos_q[i];
        act_vpos_q[i] <= stg_vpos_q[i];
        act_w_q[i]    <= stg_w_q[i];
        act_h_q[i]    <= stg_h_q[i];
        act_en_q[i]   <= stg_en_q[i];
      end
    end
  end

  // On the copy edge the lookup forwards staging so post-copy data appears alongside frame_upd_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spr_hpos_o <= '0;
      spr_vpos_o <= '0;
      spr_w_o    <= '0;
      spr_h_o    <= '0;
      spr_en_o   <= 1'b0;
    end else if (copy) begin
      spr_hpos_o <= stg_hpos_q[lk_idx];
      spr_vpos_o <= stg_vpos_q[lk_idx];
      spr_w_o    <= stg_w_q[lk_idx];
      spr_h_o    <= stg_h_q[lk_idx];
      spr_en_o   <= stg_en_q[lk_idx];
    end else begin
      spr_hpos_o <= act_hpos_q[lk_idx];
      spr_vpos_o <= act_vpos_q[lk_idx];
      spr_w_o    <= act_w_q[lk_idx];
      spr_h_o    <= act_h_q[lk_idx];
      spr_en_o   <= act_en_q[lk_idx];
    end
  end

`ifdef SPRITE_POS_REGS_READBACK_EN
  logic [31:0] rd_mux;
  logic [31:0] rdat_q;

  always_comb begin
    rd_mux = '0;
    if (adr_ok) begin
      case (adr_reg)
        2'd0:    rd_mux = {4'h0, stg_vpos_q[wr_idx], 4'h0, stg_hpos_q[wr_idx]};
        2'd1:    rd_mux = {16'h0, stg_h_q[wr_idx], stg_w_q[wr_idx]};
        2'd2:    rd_mux = {31'h0, stg_en_q[wr_idx]};
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdat_q <= '0;
    end else if (req_valid) begin
      rdat_q <= wb.wb_req.we ? 32'h0 : rd_mux;
    end else if (!req) begin
      rdat_q <= '0;
    end
  end

  assign wb.wb_resp = {ack_q, rdat_q};
`else
  assign wb.wb_resp = {ack_q, 32'h0};
`endif

endmodule

// File: tb/tb_sprite_pos_regs.sv
// Self-checking bench for sprite_pos_regs: vector table of writes/vsyncs/lookups, a lookup
// scoreboard queue, and hand-written sequences for coincident copy, cyc abort and async reset.
module tb_sprite_pos_regs;

  typedef struct packed {
    logic [11:0] hpos;
    logic [11:0] vpos;
    logic [7:0]  w;
    logic [7:0]  h;
    logic        en;
  } spr_t;

  typedef struct {
    int   idx;
    spr_t e;
  } lk_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          idx;
    spr_t        e;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } rd_t;

`ifdef SPRITE_POS_REGS_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  localparam spr_t DEF  = '{hpos: 12'd0, vpos: 12'd0, w: 8'd16, h: 8'd16, en: 1'b0};
  localparam spr_t ZERO = '{hpos: 12'd0, vpos: 12'd0, w: 8'd0, h: 8'd0, en: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        vsync = 1'b0;
  logic [4:0]  spr_idx = '0;
  logic [11:0] spr_hpos;
  logic [11:0] spr_vpos;
  logic [7:0]  spr_w;
  logic [7:0]  spr_h;
  logic        spr_en;
  logic        frame_upd;

  int n_checks = 0;
  int n_fail   = 0;

  lk_t  lk_q[$];
  bit   lk_pend = 1'b0;
  spr_t act_m[32];
  vec_t vecs[9];
  rd_t  rds[8];

  sprite_pos_regs_if wb_if ();

  sprite_pos_regs dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (wb_if),
    .vsync_i     (vsync),
    .spr_idx_i   (spr_idx),
    .spr_hpos_o  (spr_hpos),
    .spr_vpos_o  (spr_vpos),
    .spr_w_o     (spr_w),
    .spr_h_o     (spr_h),
    .spr_en_o    (spr_en),
    .frame_upd_o (frame_upd)
  );

  always #5 clk = ~clk;

  function automatic spr_t cur_spr();
    return '{hpos: spr_hpos, vpos: spr_vpos, w: spr_w, h: spr_h, en: spr_en};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // One lookup cycle: compare the index driven last cycle, then optionally drive a new one.
  task automatic lk_cycle(input bit drv, input int idx, input spr_t e);
    lk_t  ent;
    spr_t got;
    @(negedge clk);
    if (lk_pend) begin
      ent = lk_q.pop_front();
      got = cur_spr();
      n_checks++;
      if (got !== ent.e) begin
        n_fail++;
        $display("FAIL lookup idx=%0d: got %h, required %h", ent.idx, got, ent.e);
      end
    end
    if (drv) begin
      spr_idx = 5'(idx);
      lk_q.push_back('{idx: idx, e: e});
    end
    lk_pend = drv;
  endtask

  task automatic lookup(input int idx, input spr_t e);
    lk_cycle(1'b1, idx, e);
    lk_cycle(1'b0, 0, e);
  endtask

  task automatic bus_idle();
    wb_if.cs         = 1'b0;
    wb_if.wb_req.cyc = 1'b0;
    wb_if.wb_req.stb = 1'b0;
    wb_if.wb_req.we  = 1'b0;
  endtask

  task automatic bus_req(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    wb_if.cs         = 1'b1;
    wb_if.wb_req.cyc = 1'b1;
    wb_if.wb_req.stb = 1'b1;
    wb_if.wb_req.we  = we;
    wb_if.wb_req.adr = adr;
    wb_if.wb_req.dat = dat;
    wb_if.wb_req.sel = sel;
  endtask

  // Classic cycle with strobe held one extra cycle after ack.
  task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] rexp);
    @(posedge clk); #1;
    bus_req(we, adr, dat, sel);
    check("ack_low_at_req", 64'(wb_if.wb_resp.ack), 64'd0);
    check("dat_zero_at_req", 64'(wb_if.wb_resp.dat), 64'd0);
    @(posedge clk); #1;
    check("ack_after_1cyc", 64'(wb_if.wb_resp.ack), 64'd1);
    if (!we) check("read_dat", 64'(wb_if.wb_resp.dat), 64'(rexp));
    @(posedge clk); #1;
    check("ack_held", 64'(wb_if.wb_resp.ack), 64'd1);
    bus_idle();
    @(posedge clk); #1;
    check("ack_fall", 64'(wb_if.wb_resp.ack), 64'd0);
    check("dat_zero_after", 64'(wb_if.wb_resp.dat), 64'd0);
  endtask

  task automatic vsync_pulse(input bit chk, input spr_t e);
    @(posedge clk); #1;
    vsync = 1'b1;
    check("frame_upd_pre", 64'(frame_upd), 64'd0);
    @(posedge clk); #1;
    check("frame_upd_pulse", 64'(frame_upd), 64'd1);
    if (chk) check("lookup_post_copy", 64'(cur_spr()), 64'(e));
    @(posedge clk); #1;
    check("frame_upd_once", 64'(frame_upd), 64'd0);
    vsync = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    spr_t e7;
    wb_if.wb_req = '0;
    bus_idle();
    for (int i = 0; i < 32; i++) act_m[i] = DEF;

    vecs[0] = '{32'h50,  32'h0064_00C8, 4'hF, 5,  '{12'd200, 12'd100, 8'd16, 8'd16, 1'b0}};
    vecs[1] = '{32'h34,  32'h0000_2040, 4'h1, 3,  '{12'd0, 12'd0, 8'h40, 8'd16, 1'b0}};
    vecs[2] = '{32'h68,  32'h0000_0001, 4'hF, 6,  '{12'd0, 12'd0, 8'd16, 8'd16, 1'b1}};
    vecs[3] = '{32'h200, 32'hFFFF_FFFF, 4'hF, 0,  DEF};
    vecs[4] = '{32'h5C,  32'hFFFF_FFFF, 4'hF, 5,  '{12'd200, 12'd100, 8'd16, 8'd16, 1'b0}};
    vecs[5] = '{32'h50,  32'h0ABC_0DEF, 4'h6, 5,  '{12'hDC8, 12'h0BC, 8'd16, 8'd16, 1'b0}};
    vecs[6] = '{32'h1F4, 32'h0000_0305, 4'hF, 31, '{12'd0, 12'd0, 8'd5, 8'd3, 1'b0}};
    vecs[7] = '{32'h1F0, 32'h0FFF_0FFF, 4'hF, 31, '{12'hFFF, 12'hFFF, 8'd5, 8'd3, 1'b0}};
    vecs[8] = '{32'h10,  32'hF123_F456, 4'hF, 1,  '{12'h456, 12'h123, 8'd16, 8'd16, 1'b0}};

    rds[0] = '{32'h50,  32'h00BC_0DC8};
    rds[1] = '{32'h34,  32'h0000_1040};
    rds[2] = '{32'h68,  32'h0000_0001};
    rds[3] = '{32'h5C,  32'h0000_0000};
    rds[4] = '{32'h200, 32'h0000_0000};
    rds[5] = '{32'h1F4, 32'h0000_0305};
    rds[6] = '{32'h10,  32'h0123_0456};
    rds[7] = '{32'h58,  32'h0000_0000};

    // Reset with vsync already high: release must not trigger a copy.
    vsync = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 64'(wb_if.wb_resp.ack), 64'd0);
    check("rst_dat", 64'(wb_if.wb_resp.dat), 64'd0);
    check("rst_lookup", 64'(cur_spr()), 64'(ZERO));
    check("rst_frame_upd", 64'(frame_upd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_copy_vsync_high_at_release", 64'(frame_upd), 64'd0);
    end
    vsync = 1'b0;

    for (int i = 0; i < 32; i++) lk_cycle(1'b1, i, DEF);
    lk_cycle(1'b0, 0, DEF);

    for (int v = 0; v < 9; v++) begin
      wb_access(1'b1, vecs[v].adr, vecs[v].dat, vecs[v].sel, 32'h0);
      lookup(vecs[v].idx, act_m[vecs[v].idx]);
      vsync_pulse(1'b1, vecs[v].e);
      lookup(vecs[v].idx, vecs[v].e);
      act_m[vecs[v].idx] = vecs[v].e;
    end

    for (int r = 0; r < 8; r++) wb_access(1'b0, rds[r].adr, 32'h0, 4'hF, RB ? rds[r].dat : 32'h0);

    // Write committing on the same edge as the copy lands in staging only.
    e7 = DEF;
    e7.en = 1'b1;
    @(negedge clk);
    spr_idx = 5'd7;
    @(posedge clk); #1;
    bus_req(1'b1, 32'h78, 32'h1, 4'hF);
    vsync = 1'b1;
    @(posedge clk); #1;
    check("coinc_ack", 64'(wb_if.wb_resp.ack), 64'd1);
    check("coinc_frame_upd", 64'(frame_upd), 64'd1);
    check("coinc_en_old", 64'(spr_en), 64'd0);
    bus_idle();
    vsync = 1'b0;
    @(posedge clk); #1;
    check("coinc_ack_fall", 64'(wb_if.wb_resp.ack), 64'd0);
    lookup(7, DEF);
    vsync_pulse(1'b1, e7);
    lookup(7, e7);

    // Dropping cyc mid-cycle drops ack on the next edge even with stb still high.
    @(posedge clk); #1;
    bus_req(1'b1, 32'h80, 32'h0000_0011, 4'hF);
    @(posedge clk); #1;
    check("abort_ack", 64'(wb_if.wb_resp.ack), 64'd1);
    wb_if.wb_req.cyc = 1'b0;
    @(posedge clk); #1;
    check("abort_ack_fall", 64'(wb_if.wb_resp.ack), 64'd0);
    @(posedge clk); #1;
    check("abort_ack_stays_low", 64'(wb_if.wb_resp.ack), 64'd0);
    bus_idle();

    // Asynchronous reset while ack is high.
    @(negedge clk);
    spr_idx = 5'd5;
    @(posedge clk); #1;
    bus_req(1'b1, 32'h20, 32'h0005_0005, 4'hF);
    @(posedge clk); #1;
    check("pre_rst_ack", 64'(wb_if.wb_resp.ack), 64'd1);
    check("pre_rst_hpos", 64'(spr_hpos), 64'h0DC8);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ack", 64'(wb_if.wb_resp.ack), 64'd0);
    check("async_rst_lookup", 64'(cur_spr()), 64'(ZERO));
    check("async_rst_frame_upd", 64'(frame_upd), 64'd0);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    vsync_pulse(1'b1, DEF);
    lookup(2, DEF);
    lookup(5, DEF);
    lookup(7, DEF);
    lookup(31, DEF);
    wb_access(1'b0, 32'h50, 32'h0, 4'hF, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
